exp2_pipe: RTL

- Pipelined base-2 exponential stage. It sits directly downstream of the constant multiplier in the nonlinear function module.
- It consumes x·log2e (or x·(α±log2e) for GELU/SiLU) in signed fixed point and produces 2^x in the same format.
- Method: split the input into integer part u and fractional part v, approximate 2^v ≈ 1+v, then barrel-shift by u with saturation.
- Output feeds the accumulate/divide stages (softmax denominator, sigmoid reciprocal).

---
 rtl/exp2_pipe.sv | 117 +++++++++++
 1 files changed

// File: rtl/exp2_pipe.sv
// Three-stage base-2 exponential: split x into integer/fraction, approximate
// 2^v as 1+v, then barrel-shift by the integer part with saturation.
module exp2_pipe #(
    parameter int unsigned Bf              = 8,
    parameter int unsigned FIX_POINT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [FIX_POINT_WIDTH-1:0] in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [FIX_POINT_WIDTH-1:0] out_data,
    output logic                       out_last
);

    localparam int unsigned W       = FIX_POINT_WIDTH;
    localparam int unsigned UW      = W - Bf;
    localparam int unsigned MW      = Bf + 1;
    localparam int unsigned SW      = $clog2(Bf + 2);
    localparam int          SAT_TH  = int'(W) - 1 - int'(Bf);
    localparam int          ZERO_TH = -(int'(Bf) + 1);
    localparam int          MAX_SH  = int'(Bf) + 1;
    localparam logic [W-1:0] SAT_VAL = {1'b0, {(W-1){1'b1}}};

    logic advance;

    // S1: integer part (floor) and fraction
    logic                 s1_valid;
    logic                 s1_last;
    logic signed [UW-1:0] s1_u;
    logic [Bf-1:0]        s1_v;

    // S2: mantissa, shift amount and range class
    logic                 s2_valid;
    logic                 s2_last;
    logic [MW-1:0]        s2_mant;
    logic [SW-1:0]        s2_shamt;
    logic                 s2_neg;
    logic                 s2_sat;
    logic                 s2_zero;

    int                   u_int;
    int                   u_mag;
    logic [MW-1:0]        mant_c;
    logic [SW-1:0]        shamt_c;
    logic                 sat_c;
    logic                 zero_c;
    logic                 neg_c;
    logic [W-1:0]         res_c;

    // Whole pipe moves as one; an empty output slot never blocks
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Classify the integer part coming out of S1
    always_comb begin
        u_int   = int'(s1_u);
        u_mag   = (u_int < 0) ? -u_int : u_int;
        mant_c  = {1'b1, s1_v};
        sat_c   = (u_int >= SAT_TH);
        zero_c  = (u_int <= ZERO_TH);
        neg_c   = s1_u[UW-1];
        shamt_c = (u_mag > MAX_SH) ? SW'(MAX_SH) : SW'(u_mag);
    end

    // Shift and saturate the S2 word; result is never negative
    always_comb begin
        res_c = '0;
        if (s2_sat) begin
            res_c = SAT_VAL;
        end else if (s2_zero) begin
            res_c = '0;
        end else if (!s2_neg) begin
            res_c = W'(s2_mant) << s2_shamt;
        end else begin
            res_c = W'(s2_mant) >> s2_shamt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_u      <= '0;
            s1_v      <= '0;
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            s2_mant   <= '0;
            s2_shamt  <= '0;
            s2_neg    <= 1'b0;
            s2_sat    <= 1'b0;
            s2_zero   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s1_last   <= in_last;
            s1_u      <= in_data[W-1:Bf];
            s1_v      <= in_data[Bf-1:0];
            s2_valid  <= s1_valid;
            s2_last   <= s1_last;
            s2_mant   <= mant_c;
            s2_shamt  <= shamt_c;
            s2_neg    <= neg_c;
            s2_sat    <= sat_c;
            s2_zero   <= zero_c;
            out_valid <= s2_valid;
            out_data  <= res_c;
            out_last  <= s2_last;
        end
    end

endmodule
